// File: rtl/mips_pkg.sv
// Shared MIPS constants and decode payload for the front-end pipeline stages.
package mips_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned OP_W  = 6;

  typedef enum logic [OP_W-1:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_ADDI  = 6'h08,
    OP_ADDIU = 6'h09,
    OP_SLTI  = 6'h0A,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_LUI   = 6'h0F,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  localparam logic [OP_W-1:0]  FUNCT_JR         = 6'h08;
  localparam logic [REG_W-1:0] REG_RA           = 5'd31;
  localparam logic [XLEN-1:0]  NOP              = 32'h0000_0000;
  localparam logic [XLEN-1:0]  RESET_PC_DEFAULT = 32'h0000_0000;

  // Register-file facing fields extracted from one instruction word
  typedef struct packed {
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] dest;
    logic             regwrite;
  } decode_t;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational field split of an instruction word into register addresses,
// write destination and an unqualified write enable.
module instr_field_decode
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] instruction,
  output decode_t         fields
);

  logic [OP_W-1:0]  opcode;
  logic [OP_W-1:0]  funct;
  logic [REG_W-1:0] rd;
  logic             unused_shamt;

  assign opcode       = instruction[31:26];
  assign funct        = instruction[5:0];
  assign rd           = instruction[15:11];
  assign unused_shamt = ^instruction[10:6];

  always_comb begin
    fields          = '0;
    fields.rs       = instruction[25:21];
    fields.rt       = instruction[20:16];
    fields.dest     = instruction[20:16];
    fields.regwrite = 1'b0;
    // rd = 0 still writes; the register file drops writes to $0
    case (opcode)
      OP_RTYPE: begin
        fields.dest     = rd;
        fields.regwrite = (funct != FUNCT_JR);
      end
      OP_JAL: begin
        fields.dest     = REG_RA;
        fields.regwrite = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW:
        fields.regwrite = 1'b1;
      default: fields.regwrite = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_decode_stage.sv
// PC, instruction fetch, IF/ID pipeline register, field decode and
// load-use hazard detection against the EX stage.
module fetch_decode_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              branch_taken,
  input  logic [XLEN-1:0]   branch_target,
  output logic [XLEN-1:0]   imem_addr,
  input  logic [XLEN-1:0]   imem_data,
  output logic [XLEN-1:0]   instruction,
  output logic [XLEN-1:0]   pc_plus4,
  output logic              valid,
  output logic [REG_W-1:0]  address1,
  output logic [REG_W-1:0]  address2,
  output logic [REG_W-1:0]  dest,
  output logic              regwrite,
  input  logic              ex_memread,
  input  logic [REG_W-1:0]  ex_rt,
  output logic              hazard_stall
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_inc;
  logic            hold;
  logic            squash;
  logic            unused_target_lsb;
  decode_t         fields;

  assign pc_inc            = pc + XLEN'(4);
  assign hold              = stall | hazard_stall;
  assign squash            = flush | branch_taken;
  assign unused_target_lsb = ^branch_target[1:0];
  assign imem_addr         = pc;

  // Redirect wins over hold so a stalled fetch can still be steered away
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (branch_taken) begin
      pc <= {branch_target[31:2], 2'b00};
    end else if (!hold) begin
      pc <= pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || squash) begin
      instruction <= NOP;
      pc_plus4    <= '0;
      valid       <= 1'b0;
    end else if (!hold) begin
      instruction <= imem_data;
      pc_plus4    <= pc_inc;
      valid       <= 1'b1;
    end
  end

  instr_field_decode u_decode (
    .instruction (instruction),
    .fields      (fields)
  );

  assign address1 = fields.rs;
  assign address2 = fields.rt;
  assign dest     = fields.dest;
  assign regwrite = valid & fields.regwrite;

  // rt is compared for every format; a false hit only costs one bubble
  assign hazard_stall = valid & ex_memread & (ex_rt != '0) &
                        ((ex_rt == fields.rs) | (ex_rt == fields.rt));

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage: decode vector table plus hand-written
// sequences for reset, load-use stall, branch-over-stall, flush and PC wrap.
module tb_fetch_decode_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, branch_taken, ex_memread;
  logic [31:0] branch_target, imem_data;
  logic [4:0]  ex_rt;
  logic [31:0] imem_addr, instruction, pc_plus4;
  logic        valid, regwrite, hazard_stall;
  logic [4:0]  address1, address2, dest;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc;

  fetch_decode_stage #(.RESET_PC(32'h0000_0040)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .instruction(instruction), .pc_plus4(pc_plus4), .valid(valid),
    .address1(address1), .address2(address2), .dest(dest),
    .regwrite(regwrite), .ex_memread(ex_memread), .ex_rt(ex_rt),
    .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  dst;
    logic        rw;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{32'h012A_4020, 5'd9,  5'd10, 5'd8,  1'b1}; // add $8,$9,$10
    vecs[1] = '{32'h0C00_0010, 5'd0,  5'd0,  5'd31, 1'b1}; // jal
    vecs[2] = '{32'h03E0_0008, 5'd31, 5'd0,  5'd0,  1'b0}; // jr $31
    vecs[3] = '{32'h8D28_0004, 5'd9,  5'd8,  5'd8,  1'b1}; // lw
    vecs[4] = '{32'hAD28_0004, 5'd9,  5'd8,  5'd8,  1'b0}; // sw
    vecs[5] = '{32'h3C01_1234, 5'd0,  5'd1,  5'd1,  1'b1}; // lui
    vecs[6] = '{32'h1109_0003, 5'd8,  5'd9,  5'd9,  1'b0}; // beq
    vecs[7] = '{32'h0800_0010, 5'd0,  5'd0,  5'd0,  1'b0}; // j
    vecs[8] = '{32'h2128_0005, 5'd9,  5'd8,  5'd8,  1'b1}; // addi
    vecs[9] = '{32'h0000_0000, 5'd0,  5'd0,  5'd0,  1'b1}; // sll $0 (nop)

    reset = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
    branch_target = '0; ex_memread = 1'b0; ex_rt = '0;
    imem_data = 32'hDEAD_BEEF;

    // Reset state
    step();
    step();
    exp_pc = 32'h40;
    chk("reset imem_addr", imem_addr, exp_pc);
    chk("reset valid", 32'(valid), 32'd0);
    chk("reset instruction", instruction, 32'h0);
    chk("reset pc_plus4", pc_plus4, 32'h0);
    chk("reset regwrite", 32'(regwrite), 32'd0);
    chk("reset hazard", 32'(hazard_stall), 32'd0);
    chk("reset addr1", 32'(address1), 32'd0);
    chk("reset addr2", 32'(address2), 32'd0);
    chk("reset dest", 32'(dest), 32'd0);

    // Release: PC walks 40,44,48 and valid rises
    reset = 1'b0;
    imem_data = 32'h012A_4020;
    step();
    chk("release imem_addr", imem_addr, 32'h44);
    chk("release valid", 32'(valid), 32'd1);
    chk("release pc_plus4", pc_plus4, 32'h44);
    chk("add addr1", 32'(address1), 32'd9);
    chk("add addr2", 32'(address2), 32'd10);
    chk("add dest", 32'(dest), 32'd8);
    chk("add regwrite", 32'(regwrite), 32'd1);
    step();
    chk("walk imem_addr", imem_addr, 32'h48);
    exp_pc = 32'h48;

    // Decode table
    for (int i = 0; i < 10; i++) begin
      imem_data = vecs[i].instr;
      step();
      exp_pc = exp_pc + 32'd4;
      chk($sformatf("vec%0d instruction", i), instruction, vecs[i].instr);
      chk($sformatf("vec%0d valid", i), 32'(valid), 32'd1);
      chk($sformatf("vec%0d pc_plus4", i), pc_plus4, exp_pc);
      chk($sformatf("vec%0d addr1", i), 32'(address1), 32'(vecs[i].a1));
      chk($sformatf("vec%0d addr2", i), 32'(address2), 32'(vecs[i].a2));
      chk($sformatf("vec%0d dest", i), 32'(dest), 32'(vecs[i].dst));
      chk($sformatf("vec%0d regwrite", i), 32'(regwrite), 32'(vecs[i].rw));
      chk($sformatf("vec%0d imem_addr", i), imem_addr, exp_pc);
    end

    // Load-use: lw then dependent add, EX reports load to $8
    imem_data = 32'h8D28_0004;
    step();
    imem_data = 32'h0109_5020;
    step();
    exp_pc = exp_pc + 32'd8;
    ex_memread = 1'b1; ex_rt = 5'd0;
    #1;
    chk("hazard ex_rt zero", 32'(hazard_stall), 32'd0);
    ex_rt = 5'd8;
    #1;
    chk("hazard asserted", 32'(hazard_stall), 32'd1);
    imem_data = 32'h0000_0000;
    step();
    chk("hazard held instruction", instruction, 32'h0109_5020);
    chk("hazard held imem_addr", imem_addr, exp_pc);
    ex_memread = 1'b0; ex_rt = 5'd0;
    #1;
    chk("hazard released", 32'(hazard_stall), 32'd0);
    ex_memread = 1'b1; ex_rt = 5'd7;
    #1;
    chk("hazard no match", 32'(hazard_stall), 32'd0);
    ex_memread = 1'b0; ex_rt = 5'd0;

    // External stall holds PC and IF/ID
    stall = 1'b1;
    imem_data = 32'h2128_0005;
    step();
    chk("stall imem_addr", imem_addr, exp_pc);
    chk("stall instruction", instruction, 32'h0109_5020);

    // Branch beats stall
    branch_taken = 1'b1; branch_target = 32'h0000_0103;
    step();
    chk("branch imem_addr", imem_addr, 32'h100);
    chk("branch valid", 32'(valid), 32'd0);
    chk("branch instruction", instruction, 32'h0);
    chk("branch pc_plus4", pc_plus4, 32'h0);
    chk("branch regwrite", 32'(regwrite), 32'd0);
    stall = 1'b0; branch_taken = 1'b0;
    imem_data = 32'h012A_4020;
    step();
    chk("target imem_addr", imem_addr, 32'h104);
    chk("target valid", 32'(valid), 32'd1);
    chk("target pc_plus4", pc_plus4, 32'h104);

    // Flush without branch still advances PC
    flush = 1'b1;
    step();
    chk("flush imem_addr", imem_addr, 32'h108);
    chk("flush valid", 32'(valid), 32'd0);
    chk("flush instruction", instruction, 32'h0);
    flush = 1'b0;

    // PC wrap at top of address space
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
    step();
    chk("wrap pre imem_addr", imem_addr, 32'hFFFF_FFFC);
    branch_taken = 1'b0;
    imem_data = 32'h0C00_0010;
    step();
    chk("wrap imem_addr", imem_addr, 32'h0);
    chk("wrap pc_plus4", pc_plus4, 32'h0);
    chk("wrap valid", 32'(valid), 32'd1);
    chk("wrap jal dest", 32'(dest), 32'd31);
    chk("wrap jal regwrite", 32'(regwrite), 32'd1);

    // Mid-operation reset discards IF/ID
    reset = 1'b1;
    step();
    chk("midreset imem_addr", imem_addr, 32'h40);
    chk("midreset valid", 32'(valid), 32'd0);
    chk("midreset instruction", instruction, 32'h0);
    chk("midreset regwrite", 32'(regwrite), 32'd0);
    reset = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_decode_stage.md
# fetch_decode_stage

Upstream neighbour of the register-file read block. Holds the program counter, fetches from an external combinational instruction memory and registers the word in an IF/ID pipeline register. It splits the word into the two register-file read addresses, the write destination and the `regwrite` control. It also detects load-use hazards against the EX stage and stalls itself.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `stall`  in  1  external hold of PC and IF/ID
- `flush`  in  1  replace IF/ID contents with a bubble
- `branch_taken`  in  1  redirect PC this cycle
- `branch_target`  in  32  redirect address; bits [1:0] ignored (treated as 00)
- `imem_addr`  out  32  equals PC; memory returns `imem_data` combinationally in the same cycle
- `imem_data`  in  32  fetched instruction word
- `instruction`  out  32  IF/ID registered instruction
- `pc_plus4`  out  32  IF/ID registered PC+4
- `valid`  out  1  IF/ID holds a real instruction
- `address1`  out  5  rs = `instruction[25:21]`
- `address2`  out  5  rt = `instruction[20:16]`
- `dest`  out  5  destination register
- `regwrite`  out  1  decoded write enable
- `ex_memread`  in  1  EX-stage instruction is a load
- `ex_rt`  in  5  EX-stage load destination
- `hazard_stall`  out  1  load-use hazard; downstream inserts a bubble into ID/EX

## Operation
- Internal hold: `hold = stall | hazard_stall`.
- PC update priority:
  - `reset`: PC ← `RESET_PC`
  - else `branch_taken`: PC ← {`branch_target[31:2]`, 2'b00}
  - else `hold`: PC unchanged
  - else PC ← PC+4, modulo 2^32; 32'hFFFF_FFFC wraps to 0
- IF/ID update priority:
  - `reset`: `instruction` = 0, `pc_plus4` = 0, `valid` = 0
  - else `flush | branch_taken`: `instruction` = 0 (NOP), `valid` = 0, `pc_plus4` = 0
  - else `hold`: unchanged
  - else `instruction` ← `imem_data`, `pc_plus4` ← PC+4, `valid` = 1
- Decode is combinational from IF/ID:
  - opcode = `instruction[31:26]`
  - `dest`: rd (`[15:11]`) when opcode = 0; 31 when opcode = JAL (0x03); rt otherwise
  - `regwrite = valid & (R-type with funct ≠ JR (0x08) | opcode ∈ {ADDI 0x08, ADDIU 0x09, SLTI 0x0A, ANDI 0x0C, ORI 0x0D, LUI 0x0F, LW 0x23, JAL 0x03})`
  - R-type with rd = 0 still asserts `regwrite`; the register file discards writes to $0
- Hazard: `hazard_stall = valid & ex_memread & (ex_rt ≠ 0) & (ex_rt == rs | ex_rt == rt)`. Comparison is against rt regardless of format, which is conservative and accepted.
- Simultaneous events:
  - `branch_taken` beats `hold`: a stalled IF/ID is squashed and PC redirected.
  - `flush` without `branch_taken` does not stop the PC from advancing unless `hold` is high.

## Timing
- Word at `imem_addr` in cycle N appears on `instruction` in cycle N+1; decoded outputs are valid in the same cycle N+1, through combinational logic only.
- Branch penalty: the cycle after `branch_taken` shows a bubble; the target instruction arrives one cycle later.
- `hazard_stall` holds for exactly one cycle per load-use pair, provided the EX stage receives a bubble.
- Reset takes effect on the first rising edge with `reset` = 1; mid-operation reset discards IF/ID.
- Output values during reset:
  - `imem_addr` = `RESET_PC` from the following cycle
  - `valid` = 0, `regwrite` = 0, `hazard_stall` = 0, `instruction` = 0, `pc_plus4` = 0
  - `address1`/`address2`/`dest` = 0

## Structure
- Shared package `mips_pkg`:
  - opcode constants (R-type, ADDI, ADDIU, SLTI, ANDI, ORI, LUI, LW, SW, BEQ, J, JAL)
  - `FUNCT_JR`, `REG_RA = 5'd31`, `NOP = 32'h0`, `RESET_PC` default
- One combinational sub-module `instr_field_decode`: instruction in; rs/rt/dest/`regwrite` out.
- PC register, IF/ID register and hazard compare stay in the top module.

## Test plan
- Reset with `RESET_PC` = 32'h0000_0040, then release → `imem_addr` = 40, 44, 48 on consecutive cycles; `valid` rises one cycle after release.
- `imem_data` = 32'h012A_4020 (add $8,$9,$10) → next cycle `address1` = 9, `address2` = 10, `dest` = 8, `regwrite` = 1.
- 32'h8D28_0004 (lw $8,4($9)) in ID, then `ex_memread` = 1, `ex_rt` = 8 while ID holds 32'h0109_5020 (add $10,$8,$9) → `hazard_stall` = 1 for one cycle; PC and `instruction` held.
- `branch_taken` = 1, `branch_target` = 32'h0000_0103 in the same cycle as `stall` = 1 → next `imem_addr` = 32'h100; `valid` = 0; `instruction` = 0.
- PC = 32'hFFFF_FFFC with no hold → next `imem_addr` = 0; `pc_plus4` = 0.
- JAL 32'h0C00_0010 → `dest` = 31, `regwrite` = 1; JR 32'h03E0_0008 → `regwrite` = 0.
